// File: rtl/leela_pkg.sv
// -----------------------------------------------------------------------------
// leela_pkg
// Shared definitions for the leela read-DMA slice:
//   - Wishbone cycle type identifiers (classic, incrementing, end-of-burst)
//   - Wishbone burst type (linear only)
//   - read-DMA state encoding
//   - beat_cti(): cycle type to present on a beat, given the build mode and
//     whether the beat is the last one of its burst
// -----------------------------------------------------------------------------
package leela_pkg;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    localparam logic [1:0] BTE_LINEAR  = 2'b00;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        BURST = 2'd2
    } dma_state_t;

    // Classic builds never tag beats; burst builds mark only the final beat as
    // end-of-burst, so a one-beat burst is tagged end-of-burst straight away.
    function automatic logic [2:0] beat_cti(input logic burst_mode, input logic is_last);
        logic [2:0] cti;
        cti = CTI_CLASSIC;
        if (burst_mode) begin
            cti = is_last ? CTI_EOB : CTI_INCR;
        end
        return cti;
    endfunction

endpackage

// File: rtl/leela_sync_fifo.sv
// -----------------------------------------------------------------------------
// leela_sync_fifo
// Single-clock first-word fall-through FIFO with occupancy output.
// DEPTH must be a power of two, at least 2.
//
// Ports:
//   clk       in   clock
//   rst       in   asynchronous active-high reset (empties the FIFO)
//   push      in   write push_dat this cycle (ignored when full)
//   push_dat  in   WIDTH  data to write
//   pop       in   drop the head entry this cycle (ignored when empty)
//   head      out  WIDTH  current head entry, valid while empty is low
//   empty     out  no entries stored
//   level     out  log2(DEPTH)+1  number of entries stored
// -----------------------------------------------------------------------------
module leela_sync_fifo #(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 32,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic [LW-1:0]    level
);

    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [LW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && (count != DEPTH_L);
    assign do_pop  = pop && (count != '0);

    // Pointers wrap naturally because DEPTH is a power of two; a simultaneous
    // push and pop moves both pointers and leaves the count alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + LW'(1);
                2'b01:   count <= count - LW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: an entry is only observable after it is written.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    assign head  = mem[rd_ptr];
    assign empty = (count == '0);
    assign level = count;

endmodule

// File: rtl/leela_rd_dma.sv
// -----------------------------------------------------------------------------
// leela_rd_dma
// Wishbone read initiator: fetches words_i contiguous 32-bit words starting at
// base_adr_i and buffers them in a FWFT FIFO for a stream consumer. A burst only
// starts once the FIFO has room for all of it; the bus is released for at least
// one cycle between bursts so the arbiter can re-grant.
//
// Build option:
//   LEELA_RD_BURST_EN defined   : incrementing bursts of up to BURST_LEN beats
//                                 (CTI 010 ... 111, BTE 00)
//   LEELA_RD_BURST_EN undefined : classic single cycles (CTI 000), one word per
//                                 bus cycle
//
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   start_i                start request, honoured only while idle
//   base_adr_i [31:0]      byte address of the first word (bits [1:0] ignored)
//   words_i    [15:0]      word count, 0 completes immediately
//   busy_o                 transfer in progress
//   done_o                 one-cycle end-of-transfer pulse
//   err_o                  sticky abort flag, cleared by the next start
//   m_*                    Wishbone initiator port
//   pop_i                  consumer removes the FIFO head
//   dat_o, valid_o         FIFO head and not-empty flag
//   level_o                FIFO occupancy
// -----------------------------------------------------------------------------
module leela_rd_dma
    import leela_pkg::*;
#(
    parameter  int BURST_LEN  = 8,
    parameter  int FIFO_DEPTH = 32,
    localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [31:0]      base_adr_i,
    input  logic [15:0]      words_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    output logic [31:0]      m_adr_o,
    input  logic [31:0]      m_dat_i,
    output logic [3:0]       m_sel_o,
    output logic             m_we_o,
    output logic             m_stb_o,
    output logic             m_cyc_o,
    input  logic             m_ack_i,
    input  logic             m_err_i,
    output logic [2:0]       m_cti_o,
    output logic [1:0]       m_bte_o,
    input  logic             pop_i,
    output logic [31:0]      dat_o,
    output logic             valid_o,
    output logic [LVL_W-1:0] level_o
);

`ifdef LEELA_RD_BURST_EN
    localparam int   EFF_LEN    = BURST_LEN;
    localparam logic BURST_MODE = 1'b1;
`else
    localparam int   EFF_LEN    = 1;
    localparam logic BURST_MODE = 1'b0;
`endif

    localparam int               BEAT_W    = $clog2(BURST_LEN) + 1;
    localparam logic [16:0]      EFF_LEN_W = 17'(EFF_LEN);
    localparam logic [LVL_W-1:0] DEPTH_W   = LVL_W'(FIFO_DEPTH);

    dma_state_t        state_q, state_d;
    logic [31:0]       adr_q, adr_d;
    logic [15:0]       rem_q, rem_d;
    logic [BEAT_W-1:0] beats_q, beats_d;
    logic              stb_q, stb_d;
    logic [2:0]        cti_q, cti_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic              push;
    logic [16:0]       len;
    logic [LVL_W-1:0]  len_lvl;
    logic [LVL_W-1:0]  free_lvl;
    logic [LVL_W-1:0]  level;
    logic              empty;

    assign len      = ({1'b0, rem_q} > EFF_LEN_W) ? EFF_LEN_W : {1'b0, rem_q};
    assign len_lvl  = LVL_W'(len);
    assign free_lvl = DEPTH_W - level;

    // Every bus-facing output comes straight from a register so the memory
    // controller sees clean signals; an async reset therefore drops stb/cyc
    // the moment rst rises.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            adr_q   <= '0;
            rem_q   <= '0;
            beats_q <= '0;
            stb_q   <= 1'b0;
            cti_q   <= CTI_CLASSIC;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            adr_q   <= adr_d;
            rem_q   <= rem_d;
            beats_q <= beats_d;
            stb_q   <= stb_d;
            cti_q   <= cti_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic. The CTI for the upcoming beat is computed one cycle
    // ahead so it can be registered: on burst entry from the burst length, and
    // on each ack from the beats that will remain afterwards.
    always_comb begin
        state_d = state_q;
        adr_d   = adr_q;
        rem_d   = rem_q;
        beats_d = beats_q;
        stb_d   = stb_q;
        cti_d   = cti_q;
        done_d  = 1'b0;
        err_d   = err_q;
        push    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    err_d = 1'b0;
                    if (words_i == 16'd0) begin
                        done_d = 1'b1;
                    end else begin
                        adr_d   = base_adr_i & ~32'h3;
                        rem_d   = words_i;
                        state_d = WAIT;
                    end
                end
            end

            WAIT: begin
                if (free_lvl >= len_lvl) begin
                    beats_d = BEAT_W'(len);
                    stb_d   = 1'b1;
                    cti_d   = beat_cti(BURST_MODE, len == 17'd1);
                    state_d = BURST;
                end
            end

            BURST: begin
                if (m_err_i) begin
                    stb_d   = 1'b0;
                    cti_d   = CTI_CLASSIC;
                    err_d   = 1'b1;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (m_ack_i) begin
                    push    = 1'b1;
                    adr_d   = adr_q + 32'd4;
                    rem_d   = rem_q - 16'd1;
                    beats_d = beats_q - BEAT_W'(1);
                    if (beats_q == BEAT_W'(1)) begin
                        stb_d = 1'b0;
                        cti_d = CTI_CLASSIC;
                        if (rem_q == 16'd1) begin
                            done_d  = 1'b1;
                            state_d = IDLE;
                        end else begin
                            state_d = WAIT;
                        end
                    end else begin
                        cti_d = beat_cti(BURST_MODE, beats_q == BEAT_W'(2));
                    end
                end
            end

            default: begin
                stb_d   = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    leela_sync_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_dat (m_dat_i),
        .pop      (pop_i),
        .head     (dat_o),
        .empty    (empty),
        .level    (level)
    );

    assign busy_o  = (state_q != IDLE);
    assign done_o  = done_q;
    assign err_o   = err_q;
    assign m_adr_o = adr_q;
    assign m_sel_o = 4'hF;
    assign m_we_o  = 1'b0;
    assign m_stb_o = stb_q;
    assign m_cyc_o = stb_q;
    assign m_cti_o = cti_q;
    assign m_bte_o = BTE_LINEAR;
    assign valid_o = !empty;
    assign level_o = level;

endmodule

// File: tb/tb_leela_rd_dma.sv
// -----------------------------------------------------------------------------
// tb_leela_rd_dma
// Randomised scoreboard bench for leela_rd_dma. A Wishbone slave model answers
// with data derived from the address, a consumer pops at random, and a monitor
// compares every bus beat, popped word and status output against expectations
// planned from the transfer parameters. Honours LEELA_RD_BURST_EN the same way
// the design does.
// -----------------------------------------------------------------------------
module tb_leela_rd_dma;

    localparam int BURST_LEN  = 8;
    localparam int FIFO_DEPTH = 32;
    localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1;

`ifdef LEELA_RD_BURST_EN
    localparam bit BURST_MODE = 1'b1;
`else
    localparam bit BURST_MODE = 1'b0;
`endif

    typedef struct {
        logic [31:0] adr;
        logic [2:0]  cti;
        bit          last_burst;
        bit          last_xfer;
    } beat_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start_i = 1'b0;
    logic [31:0]      base_adr_i = '0;
    logic [15:0]      words_i = '0;
    logic             busy_o;
    logic             done_o;
    logic             err_o;
    logic [31:0]      m_adr_o;
    logic [31:0]      m_dat_i = '0;
    logic [3:0]       m_sel_o;
    logic             m_we_o;
    logic             m_stb_o;
    logic             m_cyc_o;
    logic             m_ack_i = 1'b0;
    logic             m_err_i = 1'b0;
    logic [2:0]       m_cti_o;
    logic [1:0]       m_bte_o;
    logic             pop_i = 1'b0;
    logic [31:0]      dat_o;
    logic             valid_o;
    logic [LVL_W-1:0] level_o;

    int    checks = 0;
    int    errors = 0;

    beat_t       exp_beats[$];
    logic [31:0] exp_data[$];
    int          level_model = 0;
    bit          exp_busy = 0;
    bit          exp_done = 0;
    bit          exp_err = 0;
    bit          gap_pending = 0;

    int    ack_pct = 100;
    int    pop_pct = 100;
    bit    pop_en = 1'b1;
    int    err_at = -1;
    int    slave_beat = 0;

    leela_rd_dma #(
        .BURST_LEN  (BURST_LEN),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_i),
        .base_adr_i (base_adr_i),
        .words_i    (words_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .err_o      (err_o),
        .m_adr_o    (m_adr_o),
        .m_dat_i    (m_dat_i),
        .m_sel_o    (m_sel_o),
        .m_we_o     (m_we_o),
        .m_stb_o    (m_stb_o),
        .m_cyc_o    (m_cyc_o),
        .m_ack_i    (m_ack_i),
        .m_err_i    (m_err_i),
        .m_cti_o    (m_cti_o),
        .m_bte_o    (m_bte_o),
        .pop_i      (pop_i),
        .dat_o      (dat_o),
        .valid_o    (valid_o),
        .level_o    (level_o)
    );

    always #5 clk = ~clk;

    // Contents of video memory as seen by the slave model.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h0100_0193) ^ 32'h5A5A_C3C3;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic timeoutFail(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s: wait bound expired at %0t", name, $time);
    endtask

    // Splits a transfer into bursts of min(BURST_LEN, remaining) words (one
    // word per bus cycle in the classic build) and records every beat's
    // address, cycle type and the word the consumer should eventually receive.
    function automatic void planTransfer(input logic [31:0] base, input int words);
        logic [31:0] a;
        int          rem;
        int          len;
        beat_t       b;
        a   = base & 32'hFFFF_FFFC;
        rem = words;
        while (rem > 0) begin
            len = BURST_MODE ? ((rem < BURST_LEN) ? rem : BURST_LEN) : 1;
            for (int k = 0; k < len; k++) begin
                b.adr        = a;
                b.cti        = !BURST_MODE ? 3'b000 : ((k == len - 1) ? 3'b111 : 3'b010);
                b.last_burst = (k == len - 1);
                b.last_xfer  = (rem - k == 1);
                exp_beats.push_back(b);
                exp_data.push_back(mem_word(a));
                a = a + 32'd4;
            end
            rem -= len;
        end
    endfunction

    // Issues one start pulse with its expectations queued beforehand.
    task automatic applyStimulus(input logic [31:0] base, input int words, input int err_beat);
        @(negedge clk);
        slave_beat = 0;
        err_at     = err_beat;
        planTransfer(base, words);
        start_i    = 1'b1;
        base_adr_i = base;
        words_i    = 16'(words);
        @(negedge clk);
        start_i    = 1'b0;
        base_adr_i = $urandom;
        words_i    = 16'($urandom);
    endtask

    // A start pulse sent while a transfer is running; nothing is expected of it.
    task automatic pulseStartWhileBusy(input logic [31:0] base, input int words);
        @(negedge clk);
        start_i    = 1'b1;
        base_adr_i = base;
        words_i    = 16'(words);
        @(negedge clk);
        start_i    = 1'b0;
    endtask

    task automatic waitIdle(input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #2;
            if (!exp_busy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) timeoutFail("wait_idle");
        @(negedge clk);
        #2;
    endtask

    task automatic waitDrain(input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #2;
            if (level_model == 0 && exp_data.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) timeoutFail("wait_drain");
    endtask

    // Wishbone slave model: while strobed, acks with probability ack_pct and
    // returns the memory word for the presented address; raises err instead of
    // ack on the requested beat of the current transfer.
    initial begin : slave
        forever begin
            @(negedge clk);
            m_ack_i = 1'b0;
            m_err_i = 1'b0;
            m_dat_i = $urandom;
            if (!rst && m_stb_o && m_cyc_o) begin
                if (err_at >= 0 && slave_beat == err_at) begin
                    m_err_i = 1'b1;
                    err_at  = -1;
                end else if (int'($urandom_range(99)) < ack_pct) begin
                    m_ack_i = 1'b1;
                    m_dat_i = mem_word(m_adr_o);
                    slave_beat++;
                end
            end
        end
    end

    // Consumer model: pops at random, sometimes while the FIFO is empty.
    initial begin : consumer
        forever begin
            @(negedge clk);
            if (rst || !pop_en) begin
                pop_i = 1'b0;
            end else begin
                pop_i = (int'($urandom_range(99)) < pop_pct);
            end
        end
    end

    // Monitor: checks the status outputs against the model each cycle, then
    // advances the model using what the bench will present at the next edge.
    initial begin : monitor
        beat_t b;
        int    n_flush;
        bit    nb;
        bit    nd;
        bit    ne;
        bit    ng;
        int    lvl_n;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                exp_beats.delete();
                exp_data.delete();
                level_model = 0;
                exp_busy    = 0;
                exp_done    = 0;
                exp_err     = 0;
                gap_pending = 0;
                continue;
            end
            checkOutput("busy", {31'd0, busy_o}, {31'd0, exp_busy});
            checkOutput("done", {31'd0, done_o}, {31'd0, exp_done});
            checkOutput("err", {31'd0, err_o}, {31'd0, exp_err});
            checkOutput("level", 32'(level_o), 32'(level_model));
            checkOutput("valid", {31'd0, valid_o}, {31'd0, (level_model != 0)});
            if (gap_pending) begin
                checkOutput("stb_gap", {31'd0, m_stb_o}, 32'd0);
            end

            nb    = exp_busy;
            nd    = 1'b0;
            ne    = exp_err;
            ng    = 1'b0;
            lvl_n = level_model;

            if (!exp_busy && start_i) begin
                ne = 1'b0;
                if (words_i == 16'd0) nd = 1'b1;
                else                  nb = 1'b1;
            end

            if (m_stb_o) begin
                if (exp_beats.size() == 0) begin
                    checkOutput("unexpected_stb", {31'd0, m_stb_o}, 32'd0);
                end else if (m_err_i) begin
                    n_flush = exp_beats.size();
                    exp_beats.delete();
                    repeat (n_flush) void'(exp_data.pop_back());
                    nb = 1'b0;
                    nd = 1'b1;
                    ne = 1'b1;
                    ng = 1'b1;
                end else if (m_ack_i) begin
                    b = exp_beats.pop_front();
                    checkOutput("beat_adr", m_adr_o, b.adr);
                    checkOutput("beat_cti", {29'd0, m_cti_o}, {29'd0, b.cti});
                    checkOutput("beat_bus", {25'd0, m_cyc_o, m_sel_o, m_we_o, m_bte_o},
                                {25'd0, 1'b1, 4'hF, 1'b0, 2'b00});
                    lvl_n++;
                    if (b.last_burst) ng = 1'b1;
                    if (b.last_xfer) begin
                        nb = 1'b0;
                        nd = 1'b1;
                    end
                end
            end

            if (pop_i && level_model != 0) begin
                if (exp_data.size() == 0) begin
                    checkOutput("pop_without_expectation", 32'(exp_data.size()), 32'd1);
                end else begin
                    checkOutput("pop_data", dat_o, exp_data.pop_front());
                end
                lvl_n--;
            end

            exp_busy    = nb;
            exp_done    = nd;
            exp_err     = ne;
            gap_pending = ng;
            level_model = lvl_n;
        end
    end

    // Global guard so the run always ends on its own.
    initial begin : watchdog
        #500000;
        errors++;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Directed scenarios first, then randomised transfers.
    initial begin : stimulus
        bit          found;
        logic [31:0] rbase;
        int          rwords;
        int          rerr;

        #23;
        checkOutput("rst_stb", {31'd0, m_stb_o}, 32'd0);
        checkOutput("rst_cyc", {31'd0, m_cyc_o}, 32'd0);
        checkOutput("rst_sel", {28'd0, m_sel_o}, 32'hF);
        checkOutput("rst_adr", m_adr_o, 32'd0);
        checkOutput("rst_cti", {29'd0, m_cti_o}, 32'd0);
        checkOutput("rst_status", {29'd0, busy_o, done_o, err_o}, 32'd0);
        checkOutput("rst_fifo", {25'd0, valid_o, 6'(level_o)}, 32'd0);
        @(negedge clk);
        #2;
        rst = 1'b0;

        $display("[TB] burst fetch: 20 words from 0x100");
        ack_pct = 100;
        pop_pct = 100;
        pop_en  = 1'b1;
        applyStimulus(32'h0000_0100, 20, -1);
        @(negedge clk);
        #2;
        checkOutput("start_to_stb_latency", {31'd0, m_stb_o}, 32'd1);
        waitIdle(400);
        waitDrain(200);

        $display("[TB] zero-length start");
        applyStimulus(32'h0000_0200, 0, -1);
        waitIdle(20);
        repeat (3) @(negedge clk);

        $display("[TB] start while busy is ignored");
        ack_pct = 70;
        applyStimulus(32'h0000_0300, 10, -1);
        pulseStartWhileBusy(32'h0000_0900, 5);
        waitIdle(400);
        waitDrain(200);

        $display("[TB] backpressure: 40 words, no pops");
        ack_pct = 100;
        pop_en  = 1'b0;
        applyStimulus(32'h0000_1000, 40, -1);
        found = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            #2;
            if (level_o == LVL_W'(FIFO_DEPTH)) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) timeoutFail("fifo_fill");
        repeat (3) @(negedge clk);
        #2;
        checkOutput("full_stb_stopped", {31'd0, m_stb_o}, 32'd0);
        checkOutput("full_level", 32'(level_o), 32'(FIFO_DEPTH));
        pop_pct = 100;
        pop_en  = 1'b1;
        repeat (8) @(negedge clk);
        #2;
        pop_en = 1'b0;
        found  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #2;
            if (m_stb_o) begin
                found = 1'b1;
                break;
            end
        end
        checkOutput("backpressure_restart", {31'd0, found}, 32'd1);
        pop_pct = 60;
        pop_en  = 1'b1;
        waitIdle(800);
        waitDrain(400);

        $display("[TB] error abort on third beat");
        ack_pct = 100;
        pop_en  = 1'b0;
        applyStimulus(32'h0000_2000, 8, 2);
        waitIdle(200);
        checkOutput("abort_err", {31'd0, err_o}, 32'd1);
        checkOutput("abort_level", 32'(level_o), 32'd2);
        checkOutput("abort_stb", {31'd0, m_stb_o}, 32'd0);
        pop_en = 1'b1;
        applyStimulus(32'h0000_3000, 3, -1);
        waitIdle(200);
        checkOutput("err_cleared", {31'd0, err_o}, 32'd0);
        waitDrain(200);

        $display("[TB] address wrap at 2^32");
        applyStimulus(32'hFFFF_FFF6, 6, -1);
        waitIdle(200);
        waitDrain(200);

        $display("[TB] randomised transfers");
        for (int t = 0; t < 12; t++) begin
            rbase   = $urandom;
            rwords  = int'($urandom_range(50));
            ack_pct = int'($urandom_range(100, 30));
            pop_pct = int'($urandom_range(100, 20));
            rerr    = -1;
            if (rwords != 0 && $urandom_range(3) == 0) begin
                rerr = int'($urandom_range(rwords - 1));
            end
            applyStimulus(rbase, rwords, rerr);
            waitIdle(3000);
        end
        waitDrain(1000);

        $display("[TB] reset in the middle of a burst");
        ack_pct = 100;
        pop_en  = 1'b0;
        applyStimulus(32'h0000_4000, 20, -1);
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            #2;
            if (slave_beat >= 5 && m_stb_o) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) timeoutFail("reach_beat5");
        rst = 1'b1;
        #1;
        checkOutput("rst_mid_stb", {31'd0, m_stb_o}, 32'd0);
        checkOutput("rst_mid_cyc", {31'd0, m_cyc_o}, 32'd0);
        checkOutput("rst_mid_valid", {31'd0, valid_o}, 32'd0);
        checkOutput("rst_mid_level", 32'(level_o), 32'd0);
        repeat (2) @(negedge clk);
        #2;
        rst = 1'b0;
        @(negedge clk);
        #2;
        checkOutput("post_rst_busy", {31'd0, busy_o}, 32'd0);
        pop_en  = 1'b1;
        pop_pct = 80;
        applyStimulus(32'h0000_5004, 11, -1);
        waitIdle(400);
        waitDrain(400);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
